// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction in a final FIX cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             w_start,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy,
  output logic             w_done,
  output logic             w_div_by_zero,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] OpMult  = 6'h18;
  localparam logic [5:0] OpMultu = 6'h19;
  localparam logic [5:0] OpDiv   = 6'h1A;
  localparam logic [5:0] OpDivu  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           r_state, w_state_next;
  logic             r_is_div, r_neg_a, r_neg_b;
  logic [WIDTH-1:0] r_b, r_acc_hi, r_acc_lo, r_hi, r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_dbz;

  logic             w_valid_op, w_signed, w_a_neg, w_b_neg, w_accept;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic             w_div_ok;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  assign w_valid_op = (w_op_code_6 == OpMult) || (w_op_code_6 == OpMultu) ||
                      (w_op_code_6 == OpDiv)  || (w_op_code_6 == OpDivu);
  assign w_signed   = ~w_op_code_6[0];
  assign w_a_neg    = w_signed & w_input1_x[WIDTH-1];
  assign w_b_neg    = w_signed & w_input2_x[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -w_input1_x : w_input1_x;
  assign w_b_mag    = w_b_neg ? -w_input2_x : w_input2_x;
  assign w_accept   = (r_state == StIdle) && w_start && w_valid_op;

  // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  // Divide: shift {rem, quo} left and keep the trial subtraction when it stays non-negative.
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix  = r_neg_a ? -r_acc_hi : r_acc_hi;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (r_cnt == '0) w_state_next = StFix;
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= (r_state == StFix);
      r_dbz  <= (r_state == StFix) && r_is_div && (r_b == '0);
      if (w_accept) begin
        r_is_div <= w_op_code_6[1];
        r_neg_a  <= w_a_neg;
        r_neg_b  <= w_b_neg;
        r_b      <= w_b_mag;
        r_acc_hi <= '0;
        r_acc_lo <= w_a_mag;
        r_cnt    <= CW'(WIDTH - 1);
      end else if (r_state == StRun) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_is_div) begin
          r_acc_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
          r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ok};
        end else begin
          r_acc_hi <= w_mul_sum[WIDTH:1];
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
      end else if (r_state == StFix) begin
        if (r_is_div) begin
          // With a zero divisor the remainder path has shifted the whole dividend into HI.
          r_hi <= w_rem_fix;
          r_lo <= (r_b == '0) ? {WIDTH{1'b1}} : w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign w_busy        = (r_state != StIdle);
  assign w_done        = r_done;
  assign w_div_by_zero = r_dbz;
  assign w_hi_x        = r_hi;
  assign w_lo_x        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus chaining, busy-ignore and reset sequences.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         w_start = 1'b0;
  logic [5:0]   w_op_code_6 = 6'h0;
  logic [W-1:0] w_input1_x = '0;
  logic [W-1:0] w_input2_x = '0;
  logic         w_busy, w_done, w_div_by_zero;
  logic [W-1:0] w_hi_x, w_lo_x;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(W)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .w_start      (w_start),
    .w_op_code_6  (w_op_code_6),
    .w_input1_x   (w_input1_x),
    .w_input2_x   (w_input2_x),
    .w_busy       (w_busy),
    .w_done       (w_done),
    .w_div_by_zero(w_div_by_zero),
    .w_hi_x       (w_hi_x),
    .w_lo_x       (w_lo_x)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive a start now (caller is away from an edge); returns just after the accepting edge.
  task automatic start_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    w_start     = 1'b1;
    w_op_code_6 = op;
    w_input1_x  = a;
    w_input2_x  = b;
    @(posedge clock); #1;
    w_start = 1'b0;
  endtask

  // Counts edges until w_done is seen; records HI/LO at edge 10 to confirm they are held.
  task automatic wait_done(output int n, output logic [W-1:0] mid_hi, output logic [W-1:0] mid_lo);
    n = 0;
    mid_hi = 'x;
    mid_lo = 'x;
    while (n < 100) begin
      @(posedge clock); #1;
      n++;
      if (n == 10) begin
        mid_hi = w_hi_x;
        mid_lo = w_lo_x;
      end
      if (w_done) break;
    end
    if (!w_done) begin
      bad++;
      total++;
      $display("FAIL timeout: got no w_done want w_done within 100 cycles");
    end
  endtask

  int           n, n2, dones;
  logic [W-1:0] mh, ml, prev_hi, prev_lo;

  initial begin
    vecs[0]  = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{6'h1B, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[3]  = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{6'h1B, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{6'h18, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
    vecs[9]  = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{6'h1A, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[11] = '{6'h19, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[12] = '{6'h1B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{6'h19, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

    // Reset state
    #12;
    check("reset_busy", 64'(w_busy), 64'd0);
    check("reset_done", 64'(w_done), 64'd0);
    check("reset_dbz", 64'(w_div_by_zero), 64'd0);
    check("reset_hilo", {w_hi_x, w_lo_x}, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Invalid code is ignored
    start_op(6'h10, 32'd3, 32'd4);
    check("bad_op_busy", 64'(w_busy), 64'd0);
    @(posedge clock); #1;
    check("bad_op_done", 64'(w_done), 64'd0);

    prev_hi = '0;
    prev_lo = '0;
    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 64'(w_busy), 64'd1);
      wait_done(n, mh, ml);
      check($sformatf("v%0d_latency", i), 64'(n), 64'd33);
      check($sformatf("v%0d_hold", i), {mh, ml}, {prev_hi, prev_lo});
      check($sformatf("v%0d_hilo", i), {w_hi_x, w_lo_x}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("v%0d_dbz", i), 64'(w_div_by_zero), 64'(vecs[i].dbz));
      check($sformatf("v%0d_busy_low", i), 64'(w_busy), 64'd0);
      @(posedge clock); #1;
      check($sformatf("v%0d_done_pulse", i), {62'd0, w_done, w_div_by_zero}, 64'd0);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // MULT then DIVU started in the w_done cycle
    start_op(6'h18, 32'hFFFFFFFD, 32'h00000005);
    wait_done(n, mh, ml);
    check("chain_mult", {w_hi_x, w_lo_x}, 64'hFFFFFFFF_FFFFFFF1);
    start_op(6'h1B, 32'd7, 32'd2);
    check("chain_busy", 64'(w_busy), 64'd1);
    wait_done(n, mh, ml);
    check("chain_latency", 64'(n), 64'd33);
    check("chain_divu", {w_hi_x, w_lo_x}, {32'd1, 32'd3});
    @(posedge clock); #1;

    // Start while busy is ignored
    start_op(6'h18, 32'd2, 32'd3);
    repeat (4) @(posedge clock);
    #1;
    w_start = 1'b1; w_op_code_6 = 6'h1B; w_input1_x = 32'd100; w_input2_x = 32'd7;
    @(posedge clock); #1;
    w_start = 1'b0;
    wait_done(n, mh, ml);
    check("busy_ign_latency", 64'(5 + n), 64'd33);
    check("busy_ign_hilo", {w_hi_x, w_lo_x}, {32'd0, 32'd6});
    @(posedge clock); #1;
    check("busy_ign_no_restart", 64'(w_busy), 64'd0);

    // Reset in the middle of a DIV
    start_op(6'h1A, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(w_busy), 64'd0);
    check("mid_rst_hilo", {w_hi_x, w_lo_x}, 64'd0);
    check("mid_rst_done", 64'(w_done), 64'd0);
    #5;
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (w_done) dones++;
    end
    check("mid_rst_no_done", 64'(dones), 64'd0);
    start_op(6'h19, 32'd4, 32'd4);
    wait_done(n2, mh, ml);
    check("post_rst_latency", 64'(n2), 64'd33);
    check("post_rst_hilo", {w_hi_x, w_lo_x}, {32'd0, 32'd16});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port w_start, input, 1 bit: request to start an operation.
REQ-005 The block SHALL have port w_op_code_6, input, 6 bits: SPECIAL function code, one of MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B.
REQ-006 The block SHALL have ports w_input1_x and w_input2_x, input, WIDTH bits each: rs (multiplicand/dividend) and rt (multiplier/divisor).
REQ-007 The block SHALL have port w_busy, output, 1 bit: an operation is in flight.
REQ-008 The block SHALL have port w_done, output, 1 bit: one-cycle pulse marking that HI/LO were just updated.
REQ-009 The block SHALL have port w_div_by_zero, output, 1 bit: qualifies w_done for a DIV/DIVU whose divisor was 0.
REQ-010 The block SHALL have ports w_hi_x and w_lo_x, output, WIDTH bits each: architectural HI and LO registers, driving MFHI/MFLO.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and FIX.
REQ-012 In IDLE, w_start=1 with a valid code SHALL capture the code and both operands, load the cycle counter with WIDTH-1, set w_busy and enter RUN at that edge.
REQ-013 In IDLE, w_start=1 with any other code SHALL be ignored, with no state change.
REQ-014 In RUN, the block SHALL perform one iteration per cycle (shift-add multiply, restoring divide) on operand magnitudes, decrementing the counter.
REQ-015 After the iteration with counter=0, the block SHALL enter FIX.
REQ-016 In FIX, the block SHALL apply sign correction, write HI/LO, clear w_busy, assert w_done for exactly one cycle and return to IDLE.
REQ-017 Latency: for a start accepted at edge k, HI/LO SHALL update and w_busy SHALL fall at edge k+WIDTH+1; w_done is high during the following cycle (34 cycles total for WIDTH=32).
REQ-018 w_start while w_busy=1 SHALL be ignored; operand or code changes during busy SHALL have no effect.
REQ-019 w_start in the w_done cycle SHALL be accepted, since the FSM is in IDLE.
REQ-020 w_hi_x/w_lo_x SHALL hold their previous values throughout an operation and change only at the FIX edge.
REQ-021 MULT/MULTU: {HI,LO} SHALL equal the full 2*WIDTH-bit signed/unsigned product.
REQ-022 DIV/DIVU: LO SHALL be the quotient and HI the remainder.
REQ-023 Signed divide SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-024 DIV of most-negative by -1 SHALL give LO=most-negative and HI=0, with no flag.
REQ-025 Divisor=0 SHALL give the same latency with HI=dividend, LO=all ones, and w_div_by_zero=1 in the w_done cycle only (0 otherwise).
REQ-026 Signed operands SHALL be converted to magnitudes at capture; results SHALL be negated in FIX per operand signs.

Reset
REQ-027 On reset=0, immediately and asynchronously, the FSM SHALL go to IDLE, with w_busy=0, w_done=0, w_div_by_zero=0, w_hi_x=0, w_lo_x=0 and counter and captured operands cleared.
REQ-028 Reset mid-operation SHALL abort the operation with no w_done pulse; the first start after reset release SHALL behave normally.

Verification
REQ-029 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, w_done high 1 cycle, w_busy high cycles 1..33.
REQ-030 MULT 0xFFFFFFFD(-3)*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; immediately chained DIVU 7/2 started in the w_done cycle -> LO=3, HI=1.
REQ-031 DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 DIVU 0x1234/0 -> HI=0x00001234, LO=0xFFFFFFFF, w_div_by_zero=1 with w_done only.
REQ-033 MULT 2*3 in flight, then w_start with new operands at cycle 5 -> ignored, result HI=0, LO=6.
REQ-034 reset=0 at cycle 10 of a DIV -> same-cycle w_busy=0 and HI/LO=0, no w_done; the next MULTU 4*4 yields LO=16.
